note_code_player: RTL and testbench
===================================

// Module: note_code_player
// PURPOSE
// - Receiving end of the 3-bit note code {volume, pitch[1:0]}: accepts one code per valid/ready handshake and plays it.
// - Output is a square-wave tone, timed by an internal 60 Hz frame tick.
// - Sits between the note-code source (switches or a sequencer) and the audio/LED output.
// - Plays one note at a time, then a silent gap, then returns to accept the next code.
// PARAMETERS
// TICK_DIV    833333  clk cycles per frame tick (50 MHz / 60 Hz)
// NOTE_TICKS  15      frame ticks a note sounds (0.25 s)
// GAP_TICKS   3       silent frame ticks after each note; 0 = no gap
// HP0         95420   half-period in clk cycles, pitch 0 (C4, 262 Hz)
// HP1         75758   half-period, pitch 1 (E4, 330 Hz)
// HP2         63776   half-period, pitch 2 (G4, 392 Hz)
// HP3         47801   half-period, pitch 3 (C5, 523 Hz)
// AMP_LO      16      sample magnitude, volume=0
// AMP_HI      96      sample magnitude, volume=1
// PORTS
// clk         in   1  system clock (CLOCK_50 at top level)
// reset_n     in   1  asynchronous active-low reset
// in_valid    in   1  in_code is valid
// in_code     in   3  {volume, pitch[1:0]}
// in_ready    out  1  player can accept a code
// audio_out   out  1  square wave; 0 while silent
// sample      out  8  signed two's-complement amplitude: +AMP / -AMP; 0 while silent
// busy        out  1  state != IDLE
// done        out  1  one-cycle pulse on return to IDLE
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE; all counters 0; in_ready=1; audio_out=0; sample=0; busy=0; done=0.
// - FSM states: IDLE, PLAY, GAP.
// - IDLE: in_ready=1. On in_valid&&in_ready at edge N:
//   - latch code; clear frame divider, tick count and tone counter; go to PLAY.
// - PLAY, from cycle N+1:
//   - audio_out=1 and sample=+AMP in cycle N+1.
//   - Both toggle after every HPx clk cycles of the latched pitch (sample alternates +AMP/-AMP).
// - Frame divider counts 0..TICK_DIV-1, emitting a tick on wrap.
// - Note length is exactly NOTE_TICKS*TICK_DIV cycles.
// - On the last tick: go to GAP if GAP_TICKS>0, else IDLE; audio_out=0 and sample=0 from the next cycle.
// - GAP: silent for GAP_TICKS*TICK_DIV cycles, then IDLE.
// - done pulses in the first IDLE cycle after PLAY or GAP; in_ready is already 1 in that cycle.
// - in_ready=0 in PLAY and GAP; in_valid is ignored there. The source holds the code; codes are never dropped or queued.
// - Simultaneous done and new in_valid: accepted in that same cycle (back-to-back notes separated only by the gap).
// - NOTE_TICKS=0 is illegal; it is guarded by an elaboration-time assertion.
// - Counter widths are sized with $clog2 of the largest parameter.
// - Tone and frame counters never wrap silently; each reloads at its terminal count.
// - reset_n low mid-note or mid-gap: immediate silence and IDLE; no done pulse.
// - sample = volume ? AMP_HI : AMP_LO, sign-applied; both AMP values must be <=127.
// STRUCTURE
// - Package note_pkg: state enum (IDLE/PLAY/GAP), code field positions (VOL_BIT=2, PITCH_MSB=1), default HPx constants.
// - Sub-module frame_tick_gen(clk, reset_n, clear, tick): reloading down-counter producing a one-cycle tick every TICK_DIV cycles.
// - The tone half-period mux (pitch -> HPx) is combinational inside this module.
// TESTING  (sim params: TICK_DIV=10, NOTE_TICKS=3, GAP_TICKS=1, HP0=4, HP1=3, HP2=2, HP3=5)
// 1. Reset released, code 3'b100 valid for 1 cycle:
//    - accepted; audio_out=1 for 4 cycles, then 0 for 4, ...; sample=+96/-96.
//    - Silent after exactly 30 cycles; done pulses 10 cycles later.
// 2. Code 3'b011: sample alternates +16/-16 with 5-cycle halves; busy=1 for 40 cycles.
// 3. in_valid held high with changing codes during PLAY: in_ready=0; no code change takes effect.
//    - The next code is accepted in the done cycle.
// 4. Back-to-back codes 3'b110 then 3'b001 with in_valid always 1:
//    - two notes of 30 cycles each with 10 silent cycles between; two done pulses.
// 5. reset_n asserted asynchronously (mid-cycle) at cycle 15 of a note:
//    - audio_out=0, sample=0, in_ready=1 immediately; no done pulse.
// 6. GAP_TICKS=0 rebuild: done coincides with the first silent cycle; the next note starts one cycle later.

Source files
------------

// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared types and constants for the note code player
package note_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam int VOL_BIT   = 2;
  localparam int PITCH_MSB = 1;

  localparam int HP0_DEF = 95420;
  localparam int HP1_DEF = 75758;
  localparam int HP2_DEF = 63776;
  localparam int HP3_DEF = 47801;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - reloading down-counter giving a one-cycle tick every TICK_DIV cycles
module frame_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV + 1);

  logic [W-1:0] cnt;

  // clear parks the counter at the top so the first tick lands TICK_DIV cycles later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || (cnt == '0)) begin
      cnt <= W'(TICK_DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = !clear && (cnt == '0);

endmodule

// File: rtl/note_code_player.sv
// rtl/note_code_player.sv - accepts a {volume, pitch} code and plays it as a square-wave note plus gap
module note_code_player
  import note_pkg::*;
#(
  parameter int TICK_DIV   = 833333,
  parameter int NOTE_TICKS = 15,
  parameter int GAP_TICKS  = 3,
  parameter int HP0        = HP0_DEF,
  parameter int HP1        = HP1_DEF,
  parameter int HP2        = HP2_DEF,
  parameter int HP3        = HP3_DEF,
  parameter int AMP_LO     = 16,
  parameter int AMP_HI     = 96
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic       audio_out,
  output logic [7:0] sample,
  output logic       busy,
  output logic       done
);

  localparam int HP_MAX = max_int(max_int(HP0, HP1), max_int(HP2, HP3));
  localparam int TONE_W = $clog2(HP_MAX + 1);
  localparam int TCNT_W = $clog2(max_int(NOTE_TICKS, GAP_TICKS) + 1);

  if (NOTE_TICKS < 1) begin : g_bad_note_ticks
    $error("NOTE_TICKS must be at least 1");
  end
  if ((AMP_LO > 127) || (AMP_HI > 127)) begin : g_bad_amp
    $error("AMP_LO and AMP_HI must not exceed 127");
  end

  state_t              state, state_nxt;
  logic [2:0]          code;
  logic [TONE_W-1:0]   tone_cnt, half_period;
  logic [TCNT_W-1:0]   tick_cnt;
  logic                phase, done_r, tick, last_tick, accept;
  logic [7:0]          amp;

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_frame_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == IDLE),
    .tick    (tick)
  );

  assign accept = in_valid && (state == IDLE);

  always_comb begin
    half_period = TONE_W'(HP0);
    case (code[PITCH_MSB:0])
      2'd1:    half_period = TONE_W'(HP1);
      2'd2:    half_period = TONE_W'(HP2);
      2'd3:    half_period = TONE_W'(HP3);
      default: half_period = TONE_W'(HP0);
    endcase
  end

  always_comb begin
    state_nxt = state;
    last_tick = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nxt = PLAY;
      PLAY: if (tick && (tick_cnt == TCNT_W'(NOTE_TICKS - 1))) begin
        last_tick = 1'b1;
        state_nxt = (GAP_TICKS > 0) ? GAP : IDLE;
      end
      GAP: if (tick && (tick_cnt == TCNT_W'(GAP_TICKS - 1))) begin
        last_tick = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      code     <= '0;
      tone_cnt <= '0;
      tick_cnt <= '0;
      phase    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (state != IDLE) && (state_nxt == IDLE);
      if (accept) begin
        code     <= in_code;
        tone_cnt <= '0;
        tick_cnt <= '0;
        phase    <= 1'b1;
      end else begin
        if (state == PLAY) begin
          if (tone_cnt == half_period - 1'b1) begin
            tone_cnt <= '0;
            phase    <= ~phase;
          end else begin
            tone_cnt <= tone_cnt + 1'b1;
          end
        end
        // tick count restarts at each phase boundary so GAP counts from zero
        if (tick) tick_cnt <= last_tick ? '0 : tick_cnt + 1'b1;
      end
    end
  end

  assign amp       = code[VOL_BIT] ? 8'(AMP_HI) : 8'(AMP_LO);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = done_r;
  assign audio_out = (state == PLAY) && phase;
  assign sample    = (state != PLAY) ? 8'd0 : (phase ? amp : (~amp + 8'd1));

endmodule

// File: tb/tb_note_code_player.sv
// tb/tb_note_code_player.sv - scoreboard bench: one DUT with a 1-tick gap, one with no gap
module tb_note_code_player;

  localparam int NOTE_LEN = 30;
  localparam int GAP_LEN  = 10;

  typedef struct packed {
    int         cyc;
    logic       aud;
    logic [7:0] smp;
    logic       bsy;
    logic       dn;
    logic       rdy;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [2:0] in_code_a = 3'b000, in_code_b = 3'b000;
  logic       in_ready_a, audio_out_a, busy_a, done_a;
  logic       in_ready_b, audio_out_b, busy_b, done_b;
  logic [7:0] sample_a, sample_b;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  rec_t q_a[$];
  rec_t q_b[$];
  int   hp_tab[4] = '{4, 3, 2, 5};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  note_code_player #(
    .TICK_DIV(10), .NOTE_TICKS(3), .GAP_TICKS(1),
    .HP0(4), .HP1(3), .HP2(2), .HP3(5), .AMP_LO(16), .AMP_HI(96)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_a), .in_code(in_code_a),
    .in_ready(in_ready_a), .audio_out(audio_out_a), .sample(sample_a),
    .busy(busy_a), .done(done_a)
  );

  note_code_player #(
    .TICK_DIV(10), .NOTE_TICKS(3), .GAP_TICKS(0),
    .HP0(4), .HP1(3), .HP2(2), .HP3(5), .AMP_LO(16), .AMP_HI(96)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_b), .in_code(in_code_b),
    .in_ready(in_ready_b), .audio_out(audio_out_b), .sample(sample_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int c, input logic a, input logic [7:0] s,
                              input logic b, input logic d, input logic r);
    rec_t x;
    x.cyc = c; x.aud = a; x.smp = s; x.bsy = b; x.dn = d; x.rdy = r;
    return x;
  endfunction

  // expected per-cycle trace of one note: tone, gap, then the done cycle
  task automatic push_note(input bit b, input int start, input logic [2:0] code,
                           input int gap, input int nmax);
    int         hp;
    logic [7:0] amp;
    logic       hi;
    rec_t       r;
    hp  = hp_tab[code[1:0]];
    amp = code[2] ? 8'd96 : 8'd16;
    for (int k = 0; (k <= NOTE_LEN + GAP_LEN * gap) && (k < nmax); k++) begin
      hi = ((k / hp) % 2) == 0;
      if (k < NOTE_LEN)                 r = mk(start + k, hi, hi ? amp : 8'd0 - amp, 1'b1, 1'b0, 1'b0);
      else if (k < NOTE_LEN + GAP_LEN * gap) r = mk(start + k, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      else                              r = mk(start + k, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
      if (b) q_b.push_back(r); else q_a.push_back(r);
    end
  endtask

  task automatic send(input bit b, input logic [2:0] code, input bit hold,
                      input int gap, input int nmax, output int acc);
    bit found;
    found = 1'b0;
    acc = -1;
    @(negedge clk);
    if (b) begin in_valid_b = 1'b1; in_code_b = code; end
    else   begin in_valid_a = 1'b1; in_code_a = code; end
    for (int t = 0; t < 200 && !found; t++) begin
      if (b ? in_ready_b : in_ready_a) begin
        found = 1'b1;
        acc = cyc + 1;
        push_note(b, acc, code, gap, nmax);
      end
      @(negedge clk);
    end
    if (!found) chk("accept_timeout", 0, 1);
    if (!hold) begin
      if (b) in_valid_b = 1'b0; else in_valid_a = 1'b0;
    end
  endtask

  task automatic wait_empty(input bit b, input int budget);
    for (int t = 0; t < budget && ((b ? q_b.size() : q_a.size()) != 0); t++) @(negedge clk);
    chk(b ? "queue_drained_b" : "queue_drained_a", b ? q_b.size() : q_a.size(), 0);
    if (b) q_b.delete(); else q_a.delete();
  endtask

  task automatic mon(input bit b);
    rec_t act, e;
    act = b ? mk(cyc, audio_out_b, sample_b, busy_b, done_b, in_ready_b)
            : mk(cyc, audio_out_a, sample_a, busy_a, done_a, in_ready_a);
    if (act.bsy || act.dn) begin
      n_chk++;
      if ((b ? q_b.size() : q_a.size()) == 0) begin
        n_fail++;
        $display("FAIL unexpected_output dut=%0d cyc=%0d busy=%b done=%b", b, act.cyc, act.bsy, act.dn);
      end else begin
        if (b) e = q_b.pop_front(); else e = q_a.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL trace dut=%0d got cyc=%0d aud=%b smp=%0d busy=%b done=%b rdy=%b expected cyc=%0d aud=%b smp=%0d busy=%b done=%b rdy=%b",
                   b, act.cyc, act.aud, $signed(act.smp), act.bsy, act.dn, act.rdy,
                   e.cyc, e.aud, $signed(e.smp), e.bsy, e.dn, e.rdy);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon(1'b0);
      mon(1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         acc1, acc2;
    logic [2:0] junk [4];
    junk = '{3'b111, 3'b000, 3'b011, 3'b101};

    repeat (3) @(negedge clk);
    chk("reset_a", int'({in_ready_a, audio_out_a, sample_a, busy_a, done_a}), int'(12'b1_0_00000000_0_0));
    chk("reset_b", int'({in_ready_b, audio_out_b, sample_b, busy_b, done_b}), int'(12'b1_0_00000000_0_0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // loud C4 then soft C5, one-cycle valid each
    send(1'b0, 3'b100, 1'b0, 1, 1000, acc1);
    wait_empty(1'b0, 100);
    send(1'b0, 3'b011, 1'b0, 1, 1000, acc1);
    wait_empty(1'b0, 100);

    // valid held with junk codes while playing; next code taken in the done cycle
    send(1'b0, 3'b110, 1'b1, 1, 1000, acc1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_code_a = junk[i % 4];
      chk("ready_low_in_play", int'(in_ready_a), 0);
    end
    send(1'b0, 3'b001, 1'b0, 1, 1000, acc2);
    chk("b2b_accept_in_done_cycle", acc2, acc1 + NOTE_LEN + GAP_LEN + 1);
    wait_empty(1'b0, 100);

    // async reset in the 15th cycle of a note
    send(1'b0, 3'b001, 1'b0, 1, 14, acc1);
    while (cyc < acc1 + 13) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_note_reset", int'({in_ready_a, audio_out_a, sample_a, busy_a, done_a}), int'(12'b1_0_00000000_0_0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    wait_empty(1'b0, 1);

    // no-gap build: done on the first silent cycle, next note one cycle later
    send(1'b1, 3'b010, 1'b1, 0, 1000, acc1);
    send(1'b1, 3'b101, 1'b0, 0, 1000, acc2);
    chk("gap0_next_start", acc2, acc1 + NOTE_LEN + 1);
    wait_empty(1'b1, 100);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
